// File: rtl/imem_arb.sv
// Instruction-memory arbiter: loader-over-fetch priority onto a single-port
// memory. Define IMEM_ARB_STARVE_EN to compile in the fetch starvation guard.
module imem_arb #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic [31:0]       f_rdata,
  output logic              f_rvalid,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic [31:0]       l_rdata,
  output logic              l_rvalid,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

  owner_e owner_r;
  owner_e owner_nxt_s;
  logic   f_gnt_s;
  logic   l_gnt_s;
  logic   starve_s;

`ifdef IMEM_ARB_STARVE_EN
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_r;

  // Count consecutive cycles fetch is requesting but denied.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (f_req && !f_gnt_s && (wait_cnt_r != CNT_MAX)) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else if (f_req && !f_gnt_s) begin
      wait_cnt_r <= wait_cnt_r;
    end else begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end
  end

  assign starve_s = f_req && (wait_cnt_r == CNT_MAX);
`else
  logic unused_max_wait_s;

  assign starve_s          = 1'b0;
  assign unused_max_wait_s = (MAX_WAIT != 32'sd0);
`endif

  // Grant decision: a starved fetch wins, otherwise the loader has priority.
  always_comb begin
    f_gnt_s = 1'b0;
    l_gnt_s = 1'b0;
    if (rst) begin
      f_gnt_s = 1'b0;
      l_gnt_s = 1'b0;
    end else if (starve_s) begin
      f_gnt_s = 1'b1;
    end else if (l_req) begin
      l_gnt_s = 1'b1;
    end else if (f_req) begin
      f_gnt_s = 1'b1;
    end else begin
      f_gnt_s = 1'b0;
      l_gnt_s = 1'b0;
    end
  end

  // Memory port steering from the granted requester.
  always_comb begin
    mem_addr = {ADDR_W{1'b0}};
    case ({f_gnt_s, l_gnt_s})
      2'b10:   mem_addr = f_addr[ADDR_W+1:2];
      2'b01:   mem_addr = l_addr[ADDR_W+1:2];
      default: mem_addr = {ADDR_W{1'b0}};
    endcase
  end

  assign f_gnt     = f_gnt_s;
  assign l_gnt     = l_gnt_s;
  assign mem_ce    = f_gnt_s | l_gnt_s;
  assign mem_we    = l_gnt_s & l_we;
  assign mem_wdata = l_wdata;

  // Next owner of the memory read data; writes return nothing.
  always_comb begin
    owner_nxt_s = OWN_NONE;
    if (l_gnt_s && !l_we) begin
      owner_nxt_s = OWN_LOAD;
    end else if (f_gnt_s) begin
      owner_nxt_s = OWN_FETCH;
    end else begin
      owner_nxt_s = OWN_NONE;
    end
  end

  // Owner tag register for the read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r <= OWN_NONE;
    end else begin
      owner_r <= owner_nxt_s;
    end
  end

  // Gating with rst drops a read granted just before reset asserts.
  assign f_rvalid = (owner_r == OWN_FETCH) && !rst;
  assign l_rvalid = (owner_r == OWN_LOAD) && !rst;

  // Only the owner sees memory data; the other side reads zero.
  always_comb begin
    f_rdata = 32'h0000_0000;
    l_rdata = 32'h0000_0000;
    if (f_rvalid) begin
      f_rdata = mem_rdata;
    end else begin
      f_rdata = 32'h0000_0000;
    end
    if (l_rvalid) begin
      l_rdata = mem_rdata;
    end else begin
      l_rdata = 32'h0000_0000;
    end
  end

  logic unused_addr_s;
  assign unused_addr_s = ^{f_addr[31:ADDR_W+2], f_addr[1:0],
                           l_addr[31:ADDR_W+2], l_addr[1:0]};

endmodule

// File: tb/tb_imem_arb.sv
// Randomized bench for imem_arb with a behavioural arbiter/memory model.
module tb_imem_arb;

  localparam int AW = 10;
  localparam int MW = 4;
`ifdef IMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, l_req, l_we;
  logic [31:0]   f_addr, l_addr, l_wdata;
  logic          f_gnt, f_rvalid, l_gnt, l_rvalid;
  logic [31:0]   f_rdata, l_rdata;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_on    = 1'b0;

  imem_arb #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rdata(f_rdata), .f_rvalid(f_rvalid),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rdata(l_rdata), .l_rvalid(l_rvalid),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory behind the arbiter: one-cycle read latency, junk on idle cycles.
  logic [31:0] tmem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_ce && mem_we) tmem[mem_addr] <= mem_wdata;
    if (mem_ce && !mem_we) mem_rdata <= tmem[mem_addr];
    else mem_rdata <= $urandom;
  end

  // Reference model: who wins, which read is outstanding, what memory holds.
  logic [31:0] shadow [0:(1<<AW)-1];
  int          waitc = 0;
  int          pend  = 0;     // 0 none, 1 fetch, 2 loader
  logic [31:0] pdata = 32'h0;
  logic [1:0]  mg;            // {fetch, loader} expected grants

  function automatic logic [1:0] model_gnt(input logic r, input logic fr,
                                           input logic lr, input int w);
    if (r) return 2'b00;
    if (fr && (!lr || (STARVE && w >= MW))) return 2'b10;
    if (lr) return 2'b01;
    return 2'b00;
  endfunction

  assign mg = model_gnt(rst, f_req, l_req, waitc);

  always @(posedge clk) begin
    if (rst) begin
      waitc <= 0;
      pend  <= 0;
    end else begin
      waitc <= (f_req && !mg[1]) ? waitc + 1 : 0;
      if (mg[1]) begin
        pend  <= 1;
        pdata <= shadow[f_addr[AW+1:2]];
      end else if (mg[0] && !l_we) begin
        pend  <= 2;
        pdata <= shadow[l_addr[AW+1:2]];
      end else begin
        pend <= 0;
        if (mg[0]) shadow[l_addr[AW+1:2]] <= l_wdata;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("f_gnt", {31'd0, f_gnt}, {31'd0, mg[1]});
      check("l_gnt", {31'd0, l_gnt}, {31'd0, mg[0]});
      check("mem_ce", {31'd0, mem_ce}, {31'd0, |mg});
      check("mem_we", {31'd0, mem_we}, {31'd0, mg[0] & l_we});
      if (|mg)
        check("mem_addr", {22'd0, mem_addr},
              {22'd0, (mg[1] ? f_addr[AW+1:2] : l_addr[AW+1:2])});
      check("mem_wdata", mem_wdata, l_wdata);
      check("f_rvalid", {31'd0, f_rvalid}, {31'd0, (!rst && pend == 1)});
      check("f_rdata", f_rdata, (!rst && pend == 1) ? pdata : 32'h0);
      check("l_rvalid", {31'd0, l_rvalid}, {31'd0, (!rst && pend == 2)});
      check("l_rdata", l_rdata, (!rst && pend == 2) ? pdata : 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    a[AW+1:2] = AW'($urandom_range(0, 15));
    return a;
  endfunction

  bit f_got, l_got;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      tmem[i]   = 32'(i);
      shadow[i] = 32'(i);
    end
    rst = 1'b1; f_req = 1'b1; f_addr = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
    tick();
    chk_on = 1'b1;

    // Reset held with fetch requesting: everything quiet.
    for (int i = 0; i < 3; i++) begin
      #4;
      check("rst_f_gnt", {31'd0, f_gnt}, 32'd0);
      check("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
      check("rst_f_rvalid", {31'd0, f_rvalid}, 32'd0);
      tick();
    end
    rst = 1'b0;
    #4 check("first_f_gnt", {31'd0, f_gnt}, 32'd1);
    tick();
    f_addr = 32'h4;
    #4 check("seq_rv0", {31'd0, f_rvalid}, 32'd1);
    check("seq_rd0", f_rdata, 32'd0);
    tick();
    f_addr = 32'h8;
    #4 check("seq_rd1", f_rdata, 32'd1);
    tick();
    f_req = 1'b0;
    #4 check("seq_rd2", f_rdata, 32'd2);
    check("seq_rv2", {31'd0, f_rvalid}, 32'd1);
    tick();
    #4 check("seq_rv_end", {31'd0, f_rvalid}, 32'd0);

    // Loader write wins over a requesting fetch.
    tick();
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'hDEAD_BEEF;
    f_req = 1'b1; f_addr = 32'h30;
    #4 check("wr_l_gnt", {31'd0, l_gnt}, 32'd1);
    check("wr_mem_we", {31'd0, mem_we}, 32'd1);
    check("wr_mem_addr", {22'd0, mem_addr}, 32'd4);
    check("wr_f_gnt", {31'd0, f_gnt}, 32'd0);
    tick();
    l_req = 1'b0; l_we = 1'b0;
    #4 check("wr_no_lrv", {31'd0, l_rvalid}, 32'd0);
    tick();
    f_addr = 32'h10;
    #4 check("wr_no_lrv2", {31'd0, l_rvalid}, 32'd0);
    tick();
    f_req = 1'b0;
    #4 check("wr_readback", f_rdata, 32'hDEAD_BEEF);
    tick();

    // Alternating owners every cycle.
    for (int i = 0; i < 3; i++) begin
      l_req = 1'b1; l_addr = 32'h20; f_req = 1'b0;
      #4 if (i > 0) check("alt_frd", f_rdata, 32'd9);
      tick();
      l_req = 1'b0; f_req = 1'b1; f_addr = 32'h24;
      #4 check("alt_lrd", l_rdata, 32'd8);
      check("alt_frv", {31'd0, f_rvalid}, 32'd0);
      tick();
    end
    f_req = 1'b0;
    #4 check("alt_frd_last", f_rdata, 32'd9);
    check("alt_lrv_last", {31'd0, l_rvalid}, 32'd0);
    tick();

    // Both requesting continuously: starvation guard pattern.
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h20; f_req = 1'b1; f_addr = 32'h24;
    for (int i = 0; i < 10; i++) begin
      #4 check("starve_f_gnt", {31'd0, f_gnt}, {31'd0, (STARVE && (i % 5 == 4))});
      tick();
    end
    l_req = 1'b0; f_req = 1'b0;
    tick();

    // Reset right after a fetch grant swallows the rvalid.
    f_req = 1'b1; f_addr = 32'h0;
    #4 check("rr_gnt", {31'd0, f_gnt}, 32'd1);
    tick();
    rst = 1'b1; f_req = 1'b0;
    #4 check("rr_rv_rst", {31'd0, f_rvalid}, 32'd0);
    tick();
    rst = 1'b0;
    #4 check("rr_rv_after", {31'd0, f_rvalid}, 32'd0);
    tick();

    // Random traffic; requesters hold their request until granted.
    f_got = 1'b1; l_got = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (!f_req || f_got) begin
        f_req  = ($urandom_range(0, 3) != 0);
        f_addr = rnd_addr();
      end
      if (!l_req || l_got) begin
        l_req   = ($urandom_range(0, 1) != 0);
        l_we    = ($urandom_range(0, 1) != 0);
        l_addr  = rnd_addr();
        l_wdata = $urandom;
      end
      rst = ($urandom_range(0, 99) == 0);
      #4;
      f_got = f_gnt;
      l_got = l_gnt;
      tick();
    end
    rst = 1'b0; f_req = 1'b0; l_req = 1'b0;
    tick();
    tick();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the instruction memory (1024 words).
REQ-002 Parameter MAX_WAIT, default 4, consecutive denied cycles after which fetch gains priority.
REQ-003 Clock and reset: the block has one clock and one reset; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 f_req  in  1  fetch read request; f_addr  in  32  fetch byte address.
REQ-007 f_gnt  out  1  fetch granted this cycle; f_rdata  out  32  read data; f_rvalid  out  1  f_rdata valid.
REQ-008 l_req  in  1  loader request; l_we  in  1  1=write, 0=read; l_addr  in  32  byte address; l_wdata  in  32  write data.
REQ-009 l_gnt  out  1  loader granted; l_rdata  out  32  read data; l_rvalid  out  1  l_rdata valid.
REQ-010 mem_ce  out  1  memory enable; mem_we  out  1  write enable; mem_addr  out  ADDR_W  word address; mem_wdata  out  32; mem_rdata  in  32  data, valid one cycle after a read access.

Function
REQ-011 At most one requester SHALL be granted per cycle; grants are combinational from current requests and registered arbitration state.
REQ-012 Default priority SHALL be loader over fetch.
REQ-013 mem_ce SHALL equal f_gnt OR l_gnt; mem_we SHALL be l_gnt AND l_we; mem_addr SHALL be granted address bits [ADDR_W+1:2]; mem_wdata SHALL be l_wdata.
REQ-014 Byte-address bits [1:0] and bits above ADDR_W+1 SHALL be ignored.
REQ-015 A granted read SHALL assert the owner's rvalid exactly one cycle after the grant, with rdata = mem_rdata; a registered owner tag SHALL record which requester the data belongs to.
REQ-016 A granted write SHALL produce no rvalid.
REQ-017 Non-owner rdata SHALL hold 0; rvalid SHALL be a single-cycle pulse per granted read.
REQ-018 Back-to-back grants SHALL be accepted every cycle (throughput one access per cycle), including alternating owners.
REQ-019 A requester holds req, addr, we, wdata stable until it sees its gnt; a deasserted request SHALL never be granted.
REQ-020 Starvation counter (0..MAX_WAIT) SHALL increment each cycle f_req=1 and f_gnt=0, clear on f_gnt or f_req=0.
REQ-021 When counter = MAX_WAIT and f_req=1, fetch SHALL be granted over the loader that cycle; counter then clears.
REQ-022 No requests: mem_ce=0, no grants, counter clears.

Reset
REQ-023 While rst=1: f_gnt, l_gnt, mem_ce, mem_we = 0; f_rvalid, l_rvalid = 0; f_rdata, l_rdata = 0; counter = 0; owner tag cleared.
REQ-024 A read granted in the cycle before rst is asserted SHALL NOT produce an rvalid.
REQ-025 The first grant SHALL be possible in the first cycle with rst=0.

Configuration
REQ-026 Macro IMEM_ARB_STARVE_EN: defined, REQ-020/021 starvation guard is compiled in.
REQ-027 Undefined: no counter exists, strict loader-over-fetch priority always applies, MAX_WAIT is unused.

Verification
REQ-028 Reset held 3 cycles with f_req=1 -> all outputs 0; first cycle after release f_gnt=1, f_rvalid=1 one cycle later.
REQ-029 Fetch-only reads at 0x0,0x4,0x8 on consecutive cycles, memory word n = n -> f_rdata 0,1,2 on consecutive cycles, f_rvalid high 3 cycles.
REQ-030 Loader writes 0xDEADBEEF to 0x10 while f_req=1 -> l_gnt=1, mem_we=1, mem_addr=4, f_gnt=0, no l_rvalid; later fetch read of 0x10 returns 0xDEADBEEF.
REQ-031 With IMEM_ARB_STARVE_EN, MAX_WAIT=4, both requesting continuously -> loader granted 4 cycles, fetch on 5th, pattern repeats; without macro fetch never granted.
REQ-032 Alternating loader read 0x20, fetch read 0x24 -> l_rvalid and f_rvalid alternate, each carrying its own word, never both high.
REQ-033 rst asserted the cycle after a fetch grant -> f_rvalid stays 0.
